// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - UART transmitter that pops one word per frame from an upstream FIFO
// Frame: start, DATA_SIZE data bits LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_fifo_drain #(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_read_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_SIZE) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_SIZE - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_EN    = (PARITY_EN != 0);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_next;
  logic [BAUD_W-1:0]    baud_cnt, baud_next;
  logic [BIT_W-1:0]     bit_cnt, bit_next;
  logic [DATA_SIZE-1:0] shreg, shreg_next;
  logic                 parity_bit, parity_next;
  logic                 tx_next;
  logic                 bit_end;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign fifo_read = (state == IDLE) & ~fifo_empty & ~reset;
  assign tx_busy   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      shreg      <= shreg_next;
      parity_bit <= parity_next;
      tx         <= tx_next;
    end
  end

  // bit_cnt indexes data bits in DATA and counts stop bits in STOP.
  always_comb begin
    state_next   = state;
    baud_next    = baud_cnt;
    bit_next     = bit_cnt;
    shreg_next   = shreg;
    parity_next  = parity_bit;
    tx_done_tick = 1'b0;
    tx_next      = 1'b1;

    case (state)
      IDLE: begin
        if (fifo_read) begin
          state_next  = START;
          baud_next   = '0;
          bit_next    = '0;
          shreg_next  = fifo_read_data;
          parity_next = (^fifo_read_data) ^ PAR_ODD;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = '0;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next  = '0;
          shreg_next = shreg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_next   = '0;
            state_next = PAR_EN ? PARITY : STOP;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          baud_next  = '0;
          bit_next   = '0;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_cnt == STOP_LAST) begin
            tx_done_tick = 1'b1;
            bit_next     = '0;
            state_next   = IDLE;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // tx is registered, so it is derived from where the FSM is heading.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
UART_TX_FIFO_DRAIN -- requirements
Module: uart_tx_fifo_drain

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, number of data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per bit period (100 MHz / 115200); legal range 2..65535.
REQ-003 SHALL have parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-004 SHALL have parameter PARITY_EN, default 0, 1 = insert parity bit after data.
REQ-005 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-006 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-009 SHALL have port fifo_read_data  input  DATA_SIZE  upstream FIFO head word, valid whenever fifo_empty=0.
REQ-010 SHALL have port fifo_read  output  1  pop request to FIFO; one-cycle pulse.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port tx_busy  output  1  high while a frame is in flight (any state except IDLE).
REQ-013 SHALL have port tx_done_tick  output  1  one-cycle pulse on last cycle of final stop bit.

Function
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL drive fifo_read combinationally = (state==IDLE) & ~fifo_empty; never high outside IDLE or during reset.
REQ-016 SHALL, on the edge where fifo_read=1, latch fifo_read_data into a DATA_SIZE-bit shift register, clear baud counter, enter START.
REQ-017 SHALL register tx; tx falls on the first edge after the fifo_read cycle (latency 1 clk).
REQ-018 SHALL hold each bit for exactly CLKS_PER_BIT cycles via a baud counter counting 0..CLKS_PER_BIT-1 and wrapping to 0.
REQ-019 SHALL drive tx=0 in START, then DATA_SIZE data bits LSB first in DATA, using a bit counter of width clog2(DATA_SIZE)+1.
REQ-020 SHALL, when PARITY_EN=1, send one PARITY bit = XOR of latched data, inverted when PARITY_ODD=1; when PARITY_EN=0, go DATA -> STOP directly.
REQ-021 SHALL drive tx=1 in STOP for STOP_BITS*CLKS_PER_BIT cycles, pulse tx_done_tick on the last of them, then enter IDLE.
REQ-022 SHALL spend at least one cycle in IDLE between frames; back-to-back frames therefore separated by exactly 1 idle-high clk.
REQ-023 SHALL ignore fifo_read_data and fifo_empty changes outside IDLE; the latched word is unaffected.
REQ-024 SHALL produce total frame length (1+DATA_SIZE+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles from tx falling edge to IDLE entry.
REQ-025 SHALL keep tx_busy=1 from the cycle after fifo_read through the tx_done_tick cycle inclusive.

Reset
REQ-026 SHALL, while reset=1, immediately force state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, fifo_read=0, counters=0, shift register=0.
REQ-027 SHALL abort any in-flight frame on reset without completing it; the popped word is discarded and not resent.
REQ-028 SHALL, after reset deasserts, start a new frame only via the REQ-015 path.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-029 SHALL verify: fifo_empty=1 for 200 cycles -> tx=1, fifo_read=0, tx_busy=0 throughout.
REQ-030 SHALL verify: single word 0x55, PARITY_EN=0 -> one fifo_read pulse; tx = 0,1,0,1,0,1,0,1,0,1 each 4 clks (40 clks); tx_done_tick once at clk 40.
REQ-031 SHALL verify: PARITY_EN=1, PARITY_ODD=0, word 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame 44 clks.
REQ-032 SHALL verify: FIFO holds 0xA3 then 0x3C -> exactly two fifo_read pulses, frames decode to 0xA3, 0x3C, exactly 1 idle-high clk between them.
REQ-033 SHALL verify: reset asserted mid-DATA (bit 3 of 0xF0) -> tx=1 same cycle, tx_busy=0, no tx_done_tick; next FIFO word transmits cleanly.
REQ-034 SHALL verify: STOP_BITS=2, word 0x00 -> stop high for 8 clks, frame 44 clks, tx_done_tick on its last cycle.
